// File: rtl/lud_ctrl_sequencer.sv
// Control-word sequencer for the LU-decomposition datapath: streams run-length coded words from
// the instruction BRAM onto CTRL_Signal. Optional macro LUD_SEQ_CYCLE_COUNT_EN adds run_cycles.
module lud_ctrl_sequencer #(
    parameter int unsigned CTRL_WIDTH      = 60,
    parameter int unsigned REP_WIDTH       = 8,
    parameter int unsigned IMEM_ADDR_WIDTH = 10
) (
    input  logic                                  CLK_100,
    input  logic                                  locked,
    input  logic                                  start,
    input  logic [IMEM_ADDR_WIDTH-1:0]            start_addr,
    output logic [IMEM_ADDR_WIDTH-1:0]            imem_addr,
    output logic                                  imem_en,
    input  logic [CTRL_WIDTH+REP_WIDTH:0]         imem_dout,
    output logic [CTRL_WIDTH-1:0]                 CTRL_Signal,
    output logic                                  bram_ZYNQ_sel,
    output logic                                  busy,
    output logic                                  done,
    output logic                                  err
`ifdef LUD_SEQ_CYCLE_COUNT_EN
    ,
    output logic [31:0]                           run_cycles
`endif
);

    localparam logic [IMEM_ADDR_WIDTH-1:0] AddrOne = IMEM_ADDR_WIDTH'(1);
    localparam logic [REP_WIDTH-1:0]       RepOne  = REP_WIDTH'(1);

    typedef enum logic [2:0] {StIdle, StHandover, StPrime, StRun, StFinish} state_e;

    state_e                       state_q, state_d;
    logic [IMEM_ADDR_WIDTH-1:0]   fp_q, fp_d;
    logic [CTRL_WIDTH-1:0]        cur_ctrl_q, cur_ctrl_d;
    logic                         cur_last_q, cur_last_d;
    logic [REP_WIDTH-1:0]         rc_q, rc_d;
    // cur_end: current word came from the all-ones address, so no successor exists.
    logic                         cur_end_q, cur_end_d;
    logic                         nxt_end_q, nxt_end_d;
    logic [CTRL_WIDTH-1:0]        ctrl_q, ctrl_d;
    logic                         sel_q, sel_d;
    logic                         busy_q, busy_d;
    logic                         done_q, done_d;
    logic                         err_q, err_d;
    logic                         fetch, load;

    always_comb begin
        state_d    = state_q;
        fp_d       = fp_q;
        cur_ctrl_d = cur_ctrl_q;
        cur_last_d = cur_last_q;
        rc_d       = rc_q;
        cur_end_d  = cur_end_q;
        nxt_end_d  = nxt_end_q;
        ctrl_d     = ctrl_q;
        sel_d      = sel_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        err_d      = err_q;
        imem_en    = 1'b0;
        fetch      = 1'b0;
        load       = 1'b0;

        unique case (state_q)
            StIdle: begin
                ctrl_d = '0;
                sel_d  = 1'b1;
                if (start) begin
                    state_d = StHandover;
                    busy_d  = 1'b1;
                    err_d   = 1'b0;
                    fp_d    = start_addr;
                end
            end
            StHandover: begin
                sel_d   = 1'b0;
                fetch   = 1'b1;
                state_d = StPrime;
            end
            StPrime: begin
                load    = 1'b1;
                fetch   = 1'b1;
                state_d = StRun;
            end
            StRun: begin
                ctrl_d = cur_ctrl_q;
                if (rc_q != '0) begin
                    rc_d = rc_q - RepOne;
                end else if (cur_last_q) begin
                    state_d = StFinish;
                end else if (cur_end_q) begin
                    state_d = StFinish;
                    err_d   = 1'b1;
                end else begin
                    load  = 1'b1;
                    fetch = 1'b1;
                end
            end
            StFinish: begin
                ctrl_d  = '0;
                sel_d   = 1'b1;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        if (fetch) begin
            imem_en   = 1'b1;
            fp_d      = fp_q + AddrOne;
            nxt_end_d = (fp_q == '1);
        end
        if (load) begin
            cur_ctrl_d = imem_dout[CTRL_WIDTH-1:0];
            rc_d       = imem_dout[CTRL_WIDTH +: REP_WIDTH];
            cur_last_d = imem_dout[CTRL_WIDTH+REP_WIDTH];
            cur_end_d  = nxt_end_q;
        end
    end

    always_ff @(posedge CLK_100) begin
        if (!locked) begin
            state_q    <= StIdle;
            fp_q       <= '0;
            cur_ctrl_q <= '0;
            cur_last_q <= 1'b0;
            rc_q       <= '0;
            cur_end_q  <= 1'b0;
            nxt_end_q  <= 1'b0;
            ctrl_q     <= '0;
            sel_q      <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            fp_q       <= fp_d;
            cur_ctrl_q <= cur_ctrl_d;
            cur_last_q <= cur_last_d;
            rc_q       <= rc_d;
            cur_end_q  <= cur_end_d;
            nxt_end_q  <= nxt_end_d;
            ctrl_q     <= ctrl_d;
            sel_q      <= sel_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

`ifdef LUD_SEQ_CYCLE_COUNT_EN
    logic [31:0] cyc_q, cyc_d;

    always_comb begin
        cyc_d = cyc_q;
        if (state_q == StIdle && start) begin
            cyc_d = '0;
        end else if (state_q == StRun && cyc_q != '1) begin
            cyc_d = cyc_q + 32'd1;
        end
    end

    always_ff @(posedge CLK_100) begin
        if (!locked) begin
            cyc_q <= '0;
        end else begin
            cyc_q <= cyc_d;
        end
    end

    assign run_cycles = cyc_q;
`endif

    assign imem_addr     = fp_q;
    assign CTRL_Signal   = ctrl_q;
    assign bram_ZYNQ_sel = sel_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign err           = err_q;

endmodule

// File: tb/tb_lud_ctrl_sequencer.sv
// Bench for lud_ctrl_sequencer: random programs in a BRAM model, checked against a walk of the
// program that expands each word by its repeat count.
module tb_lud_ctrl_sequencer;

    localparam int CW = 60;
    localparam int RW = 8;
    localparam int AW = 10;
    localparam int WW = CW + RW + 1;

    logic          clk = 1'b0;
    logic          locked;
    logic          start;
    logic [AW-1:0] start_addr;
    logic [AW-1:0] imem_addr;
    logic          imem_en;
    logic [WW-1:0] imem_dout;
    logic [CW-1:0] ctrl_sig;
    logic          sel;
    logic          busy;
    logic          done;
    logic          err;
`ifdef LUD_SEQ_CYCLE_COUNT_EN
    logic [31:0]   run_cycles;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    logic [WW-1:0] mem [1024];
    logic [CW-1:0] exp_q [$];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (imem_en) imem_dout <= mem[imem_addr];
    end

    lud_ctrl_sequencer dut (
        .CLK_100       (clk),
        .locked        (locked),
        .start         (start),
        .start_addr    (start_addr),
        .imem_addr     (imem_addr),
        .imem_en       (imem_en),
        .imem_dout     (imem_dout),
        .CTRL_Signal   (ctrl_sig),
        .bram_ZYNQ_sel (sel),
        .busy          (busy),
        .done          (done),
        .err           (err)
`ifdef LUD_SEQ_CYCLE_COUNT_EN
        ,
        .run_cycles    (run_cycles)
`endif
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [WW-1:0] mk(input bit last, input int rep, input logic [CW-1:0] c);
        logic [RW-1:0] r;
        r = RW'(rep);
        return {last, r, c};
    endfunction

    function automatic logic [CW-1:0] rnd_ctrl();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return r[CW-1:0];
    endfunction

    // Expected presentation stream: each word shown rep+1 times; stop on last or after 0x3FF.
    function automatic bit build_expect(input logic [AW-1:0] a);
        logic [AW-1:0] p;
        logic [WW-1:0] w;
        p = a;
        exp_q.delete();
        for (int k = 0; k < 1024; k++) begin
            w = mem[p];
            for (int r = 0; r <= int'(w[CW+RW-1:CW]); r++) exp_q.push_back(w[CW-1:0]);
            if (w[WW-1]) return 1'b0;
            if (p == 10'h3FF) return 1'b1;
            p = p + 10'd1;
        end
        return 1'b0;
    endfunction

    task automatic run_prog(input logic [AW-1:0] a, input bit poke);
        bit exp_err;
        int n;
        exp_err = build_expect(a);
        n = exp_q.size();
        start = 1'b1;
        start_addr = a;
        step();
        start = 1'b0;
        for (int c = 0; c <= n + 4; c++) begin
            check("ctrl", 64'(ctrl_sig), (c >= 3 && c < 3 + n) ? 64'(exp_q[c-3]) : 64'd0);
            check("sel", 64'(sel), (c >= 1 && c <= n + 2) ? 64'd0 : 64'd1);
            check("busy", 64'(busy), (c <= n + 2) ? 64'd1 : 64'd0);
            check("done", 64'(done), (c == n + 3) ? 64'd1 : 64'd0);
            if (c == 0) begin
                check("err_clr", 64'(err), 64'd0);
                check("fetch_en", 64'(imem_en), 64'd1);
                check("fetch_addr", 64'(imem_addr), 64'(a));
            end
            if (c >= n + 3) check("err", 64'(err), 64'(exp_err));
`ifdef LUD_SEQ_CYCLE_COUNT_EN
            if (c == n + 3) check("run_cycles", 64'(run_cycles), 64'(n));
`endif
            start = (poke && c <= n + 2) ? 1'($urandom_range(0, 1)) : 1'b0;
            step();
        end
    endtask

    task automatic load_random(input logic [AW-1:0] a, input int nw);
        for (int i = 0; i < nw; i++) begin
            mem[a + AW'(i)] = mk(i == nw - 1, $urandom_range(0, 3), rnd_ctrl());
        end
        mem[a + AW'(nw)] = mk(1'b0, $urandom_range(0, 3), rnd_ctrl());
    endtask

    initial begin
        logic [AW-1:0] a;
        for (int i = 0; i < 1024; i++) mem[i] = '0;
        imem_dout  = '0;
        locked     = 1'b0;
        start      = 1'b1;
        start_addr = 10'h155;

        repeat (3) step();
        check("rst_ctrl", 64'(ctrl_sig), 64'd0);
        check("rst_sel", 64'(sel), 64'd1);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_en", 64'(imem_en), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_addr", 64'(imem_addr), 64'd0);
        locked = 1'b1;
        start  = 1'b0;
        repeat (3) step();
        check("idle_busy", 64'(busy), 64'd0);
        check("idle_sel", 64'(sel), 64'd1);
        check("idle_en", 64'(imem_en), 64'd0);

        // Three-word program A, B x3, C.
        mem[10'h010] = mk(1'b0, 0, 60'hA0A_0A0A_0A0A_0A0A);
        mem[10'h011] = mk(1'b0, 2, 60'hB0B_0B0B_0B0B_0B0B);
        mem[10'h012] = mk(1'b1, 0, 60'hC0C_0C0C_0C0C_0C0C);
        mem[10'h013] = mk(1'b0, 5, 60'hDEA_DDEA_DDEA_DDEA);
        run_prog(10'h010, 1'b0);
        check("len3", 64'(exp_q.size()), 64'd5);
        run_prog(10'h010, 1'b1);

        // Single word at address 0.
        mem[10'h000] = mk(1'b1, 0, 60'h0D0_D0D0_D0D0_D0D0);
        run_prog(10'h000, 1'b0);

        // Address wrap without last word.
        mem[10'h3FE] = mk(1'b0, 1, 60'h3FE_3FE3_FE3F_E3FE);
        mem[10'h3FF] = mk(1'b0, 0, 60'h3FF_3FF3_FF3F_F3FF);
        mem[10'h000] = mk(1'b0, 0, 60'h123_4567_89AB_CDEF);
        run_prog(10'h3FE, 1'b0);
        run_prog(10'h010, 1'b0);

        for (int t = 0; t < 10; t++) begin
            a = AW'($urandom_range(0, 1000));
            load_random(a, $urandom_range(1, 5));
            run_prog(a, t[0]);
        end

        // Reset in the middle of a run.
        start = 1'b1;
        start_addr = 10'h010;
        step();
        start = 1'b0;
        repeat (4) step();
        check("mid_ctrl_b", 64'(ctrl_sig), 64'(60'hB0B_0B0B_0B0B_0B0B));
        locked = 1'b0;
        step();
        check("mid_rst_ctrl", 64'(ctrl_sig), 64'd0);
        check("mid_rst_sel", 64'(sel), 64'd1);
        check("mid_rst_busy", 64'(busy), 64'd0);
        locked = 1'b1;
        for (int c = 0; c < 6; c++) begin
            check("mid_rst_done", 64'(done), 64'd0);
            check("mid_rst_idle", 64'(busy), 64'd0);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/lud_ctrl_sequencer.md
Name: lud_ctrl_sequencer

Overview:
- Drives the CTRL_Signal bus and bram_ZYNQ_sel of the LU-decomposition datapath (two dual-port BRAM blocks, MAC, DIV, input muxes).
- Fetches precompiled control words from an external instruction BRAM (read latency 1), optionally repeats each word for a run-length, and presents exactly one word per cycle.
- Hands BRAM port A to the ZYNQ when idle and takes it back for a run, with start/busy/done handshaking to the PS.

Parameters:
- CTRL_WIDTH, 60, width of the control word driven to the datapath.
- REP_WIDTH, 8, width of the per-word repeat field.
- IMEM_ADDR_WIDTH, 10, instruction memory address width.

Ports:
- CLK_100  input  1  system clock; all logic on rising edge.
- locked  input  1  synchronous active-low reset (low = reset).
- start  input  1  run request; sampled only in IDLE.
- start_addr  input  IMEM_ADDR_WIDTH  address of the first instruction word.
- imem_addr  output  IMEM_ADDR_WIDTH  instruction BRAM address.
- imem_en  output  1  instruction BRAM read enable; BRAM dout holds when low.
- imem_dout  input  CTRL_WIDTH+REP_WIDTH+1  word = {last, repeat, ctrl}; valid one cycle after addressed with imem_en=1.
- CTRL_Signal  output  CTRL_WIDTH  registered control word to the datapath.
- bram_ZYNQ_sel  output  1  1 = ZYNQ owns BRAM port A; 0 = datapath owns it.
- busy  output  1  high from start acceptance until done.
- done  output  1  one-cycle pulse at run completion.
- err  output  1  sticky; set when the fetch address wraps without a last word; cleared on next accepted start.

Behaviour:
- Reset (locked=0 at an edge): state IDLE; CTRL_Signal=0; bram_ZYNQ_sel=1; imem_en=0; imem_addr=0; busy=0; done=0; err=0. Reset mid-run aborts immediately with no further writes: CTRL_Signal=0 forces all we bits low.
- States: IDLE, HANDOVER, PRIME, RUN, FINISH.
- IDLE: CTRL_Signal=0, bram_ZYNQ_sel=1. If start=1, go to HANDOVER; busy<=1; err<=0; latch start_addr into the fetch pointer fp.
- HANDOVER (1 cycle): bram_ZYNQ_sel<=0; imem_addr=fp, imem_en=1; fp<=fp+1. Go to PRIME.
- PRIME (1 cycle): capture imem_dout into the current-word register cur and the repeat counter rc; issue a prefetch of fp (imem_en=1, fp<=fp+1). Go to RUN.
- RUN: each cycle CTRL_Signal<=cur.ctrl.
  - If rc!=0: decrement rc; imem_en=0 (prefetched word held).
  - If rc==0 and cur.last=0: load cur/rc from imem_dout and issue the next prefetch.
  - If rc==0 and cur.last=1: go to FINISH.
- Repeat field N means the word is presented N+1 consecutive cycles; N=0 means one cycle.
- Latency: start sampled at edge 0; word 0 first appears on CTRL_Signal after edge 3 and stays continuous with no bubbles between words.
- FINISH (1 cycle): CTRL_Signal<=0; bram_ZYNQ_sel<=1; done<=1 for this cycle; busy<=0. Return to IDLE.
- start while busy: ignored. start asserted in the FINISH cycle: ignored; it must be re-asserted in IDLE.
- Address wrap: if a prefetch would pass the all-ones address and cur.last=0, behave as a last word (FINISH path) and set err=1.
- Prefetching a word past a last word is harmless; its value is never used.
- fp and imem_addr wrap modulo 2^IMEM_ADDR_WIDTH.

Optional Feature:
- Macro: LUD_SEQ_CYCLE_COUNT_EN.
- Defined: adds output run_cycles[31:0], which counts CLK_100 cycles spent in RUN.
  - Cleared on accepted start; holds after done until the next start.
  - Saturates at 0xFFFFFFFF.
  - Reset value 0.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset: hold locked=0 for 3 cycles with start=1 -> CTRL_Signal=0, bram_ZYNQ_sel=1, busy=0, done=0, imem_en=0; release with start=0 -> stays IDLE.
- Three-word program at 0x010: {0,0,A}, {0,2,B}, {1,0,C}; start at cycle 0 -> CTRL_Signal = A,B,B,B,C on cycles 3-7, then 0; done pulse in cycle 8; bram_ZYNQ_sel low in cycles 1-7.
- Single-word program {1,0,D} at 0x000 -> D for exactly 1 cycle; done 1 cycle later; busy high 4 cycles total.
- start pulses while busy and during FINISH -> no restart; second run starts only after start is reasserted in IDLE; word sequence identical.
- Wrap: start_addr=0x3FE, words without last -> words at 0x3FE and 0x3FF presented, then FINISH; err=1, done pulsed; next start clears err.
- Reset asserted in RUN after the second word -> CTRL_Signal=0 and bram_ZYNQ_sel=1 on the next cycle; no done pulse. With LUD_SEQ_CYCLE_COUNT_EN, the 3-word run gives run_cycles=5.
